// File: rtl/kbd_pkg.sv
// Shared scancode constants, decoder state encoding and event layout
// for the keyboard event queue.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_E0   = 2'd1;
    localparam logic [1:0] ST_F0   = 2'd2;
    localparam logic [1:0] ST_E0F0 = 2'd3;

    localparam int EVT_W     = 14;
    localparam int EVT_BRK   = 13;
    localparam int EVT_EXT   = 12;
    localparam int EVT_CAPS  = 11;
    localparam int EVT_ALT   = 10;
    localparam int EVT_CTRL  = 9;
    localparam int EVT_SHIFT = 8;

    function automatic logic [EVT_W-1:0] pack_evt(
        input logic       brk,
        input logic       ext,
        input logic       caps,
        input logic       alt,
        input logic       ctrl,
        input logic       shift,
        input logic [7:0] code
    );
        logic [EVT_W-1:0] e;
        e            = '0;
        e[7:0]       = code;
        e[EVT_SHIFT] = shift;
        e[EVT_CTRL]  = ctrl;
        e[EVT_ALT]   = alt;
        e[EVT_CAPS]  = caps;
        e[EVT_EXT]   = ext;
        e[EVT_BRK]   = brk;
        return e;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full queue
// is accepted only when a pop retires an entry in the same cycle.
module kbd_fifo
    import kbd_pkg::*;
#(
    parameter int WIDTH = EVT_W,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    always_comb begin
        valid    = count_q != '0;
        full     = count_q == (AW+1)'(DEPTH);
        rd_en    = pop & valid;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        rd_data  = mem_q[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: entries are only visible through count_q
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/kbd_event_fifo.sv
// PS/2 scancode decoder with modifier tracking feeding an event queue
// with overflow accounting.
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int REPEAT_EN = 0,
    parameter int BREAK_EN  = 1
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic [7:0]               ps2_data,
    input  logic                     ps2_ready,
    output logic                     ps2_nextdata_n,
    output logic [EVT_W-1:0]         evt_data,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_ovf
);

    logic [1:0]       state_q, state_d;
    logic             took_q, took_d;
    logic [511:0]     pressed_q, pressed_d;
    logic             caps_q, caps_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;

    logic             consume, done, want, drop, pop, full;
    logic             is_ext, is_brk, rep;
    logic             shift, ctrl, alt;
    logic [8:0]       key;
    logic [EVT_W-1:0] evt;

    always_comb begin
        consume   = ps2_ready & ~took_q & clrn;
        took_d    = consume;
        state_d   = state_q;
        pressed_d = pressed_q;
        caps_d    = caps_q;
        done      = 1'b0;
        is_ext    = (state_q == ST_E0) || (state_q == ST_E0F0);
        is_brk    = (state_q == ST_F0) || (state_q == ST_E0F0);
        key       = {is_ext, ps2_data};
        rep       = ~is_brk & pressed_q[key];
        if (consume) begin
            unique case (1'b1)
                ps2_data == SC_EXT: state_d = ST_E0;
                ps2_data == SC_BRK: begin
                    if (state_q == ST_IDLE)    state_d = ST_F0;
                    else if (state_q == ST_E0) state_d = ST_E0F0;
                end
                default: begin
                    state_d        = ST_IDLE;
                    done           = 1'b1;
                    pressed_d[key] = ~is_brk;
                    if (!is_brk && !is_ext && !rep && ps2_data == SC_CAPS)
                        caps_d = ~caps_q;
                end
            endcase
        end
    end

    // shift/ctrl/alt report the keys held before this key; caps shows the new lock state
    always_comb begin
        shift = pressed_q[{1'b0, SC_LSHIFT}] | pressed_q[{1'b0, SC_RSHIFT}];
        ctrl  = pressed_q[{1'b0, SC_CTRL}]   | pressed_q[{1'b1, SC_CTRL}];
        alt   = pressed_q[{1'b0, SC_ALT}]    | pressed_q[{1'b1, SC_ALT}];
        evt   = pack_evt(is_brk, is_ext, caps_d, alt, ctrl, shift, ps2_data);
        want  = done & (is_brk ? (BREAK_EN != 0) : (~rep | (REPEAT_EN != 0)));
        pop   = evt_valid & evt_ready;
        drop  = want & full & ~pop;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end else if (drop) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        end
        ps2_nextdata_n = ~consume;
        ovf            = ovf_q;
        drop_cnt       = drop_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= ST_IDLE;
            took_q    <= 1'b0;
            pressed_q <= '0;
            caps_q    <= 1'b0;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            took_q    <= took_d;
            pressed_q <= pressed_d;
            caps_q    <= caps_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    kbd_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .push    (want),
        .wr_data (evt),
        .pop     (evt_ready),
        .rd_data (evt_data),
        .valid   (evt_valid),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Bench for kbd_event_fifo: decode vectors, overflow, full push/pop,
// consume pacing and mid-sequence reset.
module tb_kbd_event_fifo;
    import kbd_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic [7:0]  ps2_data;
    logic        ps2_ready;
    logic        ps2_nextdata_n;
    logic [13:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  count;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];

    typedef struct {
        logic [7:0]  b;
        logic        push;
        logic [13:0] evt;
        logic        drain;
    } vec_t;
    vec_t vt[$];

    kbd_event_fifo #(.DEPTH(4), .REPEAT_EN(0), .BREAK_EN(1)) dut (
        .clk            (clk),
        .clrn           (clrn),
        .ps2_data       (ps2_data),
        .ps2_ready      (ps2_ready),
        .ps2_nextdata_n (ps2_nextdata_n),
        .evt_data       (evt_data),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .count          (count),
        .ovf            (ovf),
        .drop_cnt       (drop_cnt),
        .clr_ovf        (clr_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [7:0] b, input logic p,
                               input logic [13:0] e, input logic d);
        vec_t r;
        r.b = b; r.push = p; r.evt = e; r.drain = d;
        return r;
    endfunction

    // entered and left on a negedge; two cycles so the next byte is consumable
    task automatic send_byte(input logic [7:0] b);
        ps2_data  = b;
        ps2_ready = 1'b1;
        #1;
        chk("consume_strobe", ps2_nextdata_n, 1'b0);
        @(negedge clk);
        ps2_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n;
        chk({tag, "_count"}, count, exp_q.size());
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            if (evt_valid) begin
                chk(tag, evt_data, exp_q.pop_front());
                evt_ready = 1'b1;
            end else begin
                evt_ready = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        evt_ready = 1'b0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d events pending want 0",
                     tag, exp_q.size());
            exp_q.delete();
        end
        chk({tag, "_empty"}, count, 0);
    endtask

    initial begin
        logic [7:0] ov [6];
        logic [7:0] rk [5];
        ov = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        rk = '{8'h1A, 8'h1B, 8'h21, 8'h23, 8'h34};

        vt.push_back(v(8'h1C, 1, 14'h001C, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h1C, 1, 14'h201C, 1));
        vt.push_back(v(8'h12, 1, 14'h0012, 0));
        vt.push_back(v(8'h1C, 1, 14'h011C, 0));
        vt.push_back(v(8'h1C, 0, 14'h0000, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h1C, 1, 14'h211C, 1));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h12, 1, 14'h2112, 1));
        vt.push_back(v(8'hE0, 0, 14'h0000, 0));
        vt.push_back(v(8'h14, 1, 14'h1014, 0));
        vt.push_back(v(8'h22, 1, 14'h0222, 1));
        vt.push_back(v(8'hE0, 0, 14'h0000, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h14, 1, 14'h3214, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h22, 1, 14'h2022, 1));
        vt.push_back(v(8'h58, 1, 14'h0858, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h58, 1, 14'h2858, 0));
        vt.push_back(v(8'h58, 1, 14'h0058, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h58, 1, 14'h2058, 1));
        vt.push_back(v(8'h11, 1, 14'h0011, 0));
        vt.push_back(v(8'h33, 1, 14'h0433, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h11, 1, 14'h2411, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h33, 1, 14'h2033, 1));
        vt.push_back(v(8'hE0, 0, 14'h0000, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'hE0, 0, 14'h0000, 0));
        vt.push_back(v(8'h1C, 1, 14'h101C, 0));
        vt.push_back(v(8'hE0, 0, 14'h0000, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h1C, 1, 14'h301C, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'hF0, 0, 14'h0000, 0));
        vt.push_back(v(8'h1C, 1, 14'h201C, 1));

        clrn      = 1'b0;
        ps2_data  = 8'h00;
        ps2_ready = 1'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_nextdata", ps2_nextdata_n, 1'b1);
        clrn = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            send_byte(vt[i].b);
            if (vt[i].push) exp_q.push_back(vt[i].evt);
            if (vt[i].drain) drain($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            send_byte(ov[i]);
            if (i < 4) exp_q.push_back({6'h00, ov[i]});
        end
        chk("ovf_count", count, 4);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_drop", drop_cnt, 2);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("clr_ovf_flag", ovf, 1'b0);
        chk("clr_ovf_drop", drop_cnt, 0);
        drain("ovf_pop");
        send_byte(8'h35);
        chk("dropped_key_tracked", count, 0);

        for (int i = 0; i < 4; i++) begin
            send_byte(8'hF0);
            send_byte(ov[i]);
            exp_q.push_back({6'h20, ov[i]});
        end
        chk("refill_count", count, 4);
        send_byte(8'h3C);
        chk("drop1_ovf", ovf, 1'b1);
        chk("drop1_cnt", drop_cnt, 1);
        clr_ovf = 1'b1;
        send_byte(8'h43);
        clr_ovf = 1'b0;
        chk("clr_prio_ovf", ovf, 1'b0);
        chk("clr_prio_drop", drop_cnt, 0);
        send_byte(8'hF0);
        ps2_data  = 8'h2C;
        ps2_ready = 1'b1;
        evt_ready = 1'b1;
        chk("fullpp_head", evt_data, exp_q.pop_front());
        exp_q.push_back(14'h202C);
        @(negedge clk);
        ps2_ready = 1'b0;
        evt_ready = 1'b0;
        chk("fullpp_count", count, 4);
        chk("fullpp_ovf", ovf, 1'b0);
        chk("fullpp_drop", drop_cnt, 0);
        @(negedge clk);
        drain("fullpp");

        ps2_data  = 8'hE0;
        ps2_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("pace%0d", i), ps2_nextdata_n, (i % 2));
            @(negedge clk);
        end
        ps2_ready = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        exp_q.push_back(14'h101C);
        drain("pace_evt");

        for (int i = 0; i < 5; i++) send_byte(rk[i]);
        chk("pre_rst_count", count, 4);
        chk("pre_rst_ovf", ovf, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        clrn      = 1'b0;
        ps2_ready = 1'b1;
        ps2_data  = 8'h1C;
        #1;
        chk("mid_rst_valid", evt_valid, 1'b0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", ovf, 1'b0);
        chk("mid_rst_drop", drop_cnt, 0);
        chk("mid_rst_nextdata", ps2_nextdata_n, 1'b1);
        @(negedge clk);
        ps2_ready = 1'b0;
        clrn      = 1'b1;
        @(negedge clk);
        send_byte(8'h1C);
        exp_q.push_back(14'h001C);
        drain("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
